audio_voice_mix_scheduler: RTL

//  Per-sample-period scheduler that polls up to NUM_VOICES voice sources in fixed index order,

---
 rtl/audio_voice_mix_scheduler_pkg.sv | 21 ++
 rtl/audio_voice_mix_scheduler_accum.sv | 45 ++++
 rtl/audio_voice_mix_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/audio_voice_mix_scheduler_pkg.sv
// Shared types for the voice mix scheduler.
// Frame layout, FSM states and clamp limits.
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    WAIT,
    PUSH
  } mix_state_e;

  typedef struct packed {
    logic signed [31:0] left;
    logic signed [31:0] right;
  } audio_frame_t;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/audio_voice_mix_scheduler_accum.sv
// One channel of the mixer: wide signed accumulator
// with a 32-bit saturating view of the running sum.
module audio_sat_accum
  import audio_pkg::*;
#(
  parameter int ACC_W = 35
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               add_en_i,
  input  logic signed [31:0] sample_i,
  output logic signed [31:0] sat_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-32:0]       hi;

  // next sum: clear at frame start, else add sign-extended sample
  always_comb begin
    acc_d = acc_q;
    if (clear_i)
      acc_d = '0;
    else if (add_en_i)
      acc_d = acc_q + {{(ACC_W-32){sample_i[31]}}, sample_i};
  end

  // accumulator register
  always_ff @(posedge clk_i) begin
    if (rst_i)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign hi = acc_q[ACC_W-1:31];

  // clamp: sum fits in 32 bits only when the top bits all match
  always_comb begin
    sat_o = acc_q[31:0];
    if (!(hi == '0 || hi == '1))
      sat_o = acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX;
  end

endmodule

// File: rtl/audio_voice_mix_scheduler.sv
// Per-sample-period voice poller and saturating stereo mixer
// feeding the audio FIFO write port (AXI4-Stream master).
module audio_voice_mix_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_VOICES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     frame_tick,
  input  logic [NUM_VOICES-1:0]    voice_active,
  output logic [NUM_VOICES-1:0]    voice_sample_req,
  input  logic [NUM_VOICES-1:0]    voice_sample_valid,
  input  logic [NUM_VOICES*64-1:0] voice_sample_data,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [63:0]              m_axis_tdata,
  output logic                     busy,
  output logic [15:0]              overrun_count,
  output logic [NUM_VOICES-1:0]    timeout_mask
);

  localparam int IDX_W = $clog2(NUM_VOICES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int ACC_W = 32 + $clog2(NUM_VOICES) + 1;

  mix_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [15:0]           ovr_q, ovr_d;
  logic [NUM_VOICES-1:0] tmask_q, tmask_d;

  logic [NUM_VOICES-1:0] idx_oh;
  logic [NUM_VOICES-1:0] act_sh;
  logic [NUM_VOICES-1:0] vld_sh;
  logic                  cur_active;
  logic                  cur_valid;
  audio_frame_t          cur_frame;
  logic                  acc_clr;
  logic                  acc_add;
  logic signed [31:0]    left_sat;
  logic signed [31:0]    right_sat;

  assign idx_oh     = NUM_VOICES'(1) << idx_q;
  assign act_sh     = voice_active >> idx_q;
  assign vld_sh     = voice_sample_valid >> idx_q;
  assign cur_active = act_sh[0];
  assign cur_valid  = vld_sh[0];

  // frame of the voice currently being polled
  always_comb begin
    cur_frame = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (idx_q == IDX_W'(i))
        cur_frame = voice_sample_data[64*i +: 64];
  end

  // state and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      ovr_q   <= '0;
      tmask_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      ovr_q   <= ovr_d;
      tmask_q <= tmask_d;
    end
  end

  // next-state, counters and accumulator controls
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    ovr_d   = ovr_q;
    tmask_d = tmask_q;
    acc_clr = 1'b0;
    acc_add = 1'b0;

    if (frame_tick && state_q != IDLE && ovr_q != 16'hFFFF)
      ovr_d = ovr_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (frame_tick && enable) begin
          acc_clr = 1'b1;
          idx_d   = '0;
          timer_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM_VOICES))
          state_d = PUSH;
        else if (cur_active)
          state_d = REQ;
        else
          idx_d = idx_q + 1'b1;
      end
      REQ: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cur_valid) begin
          acc_add = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          tmask_d = tmask_q | idx_oh;
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PUSH: begin
        if (m_axis_tready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  audio_sat_accum #(.ACC_W(ACC_W)) u_acc_l (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (acc_clr),
    .add_en_i (acc_add),
    .sample_i (cur_frame.left),
    .sat_o    (left_sat)
  );

  audio_sat_accum #(.ACC_W(ACC_W)) u_acc_r (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (acc_clr),
    .add_en_i (acc_add),
    .sample_i (cur_frame.right),
    .sat_o    (right_sat)
  );

  assign voice_sample_req = (state_q == REQ) ? idx_oh : '0;
  assign m_axis_tvalid    = (state_q == PUSH);
  assign m_axis_tdata     = {left_sat, right_sat};
  assign busy             = (state_q != IDLE);
  assign overrun_count    = ovr_q;
  assign timeout_mask     = tmask_q;

endmodule
